pc_fetch_ifid: RTL

- Upstream/downstream companion of the instruction-memory Fetch stage.
- Owns the RV32I program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register consumed by decode.
- Handles stall (hold), branch/jump redirect (flush plus a 1-cycle bubble), misaligned-target trapping and a fetch counter.

---
 rtl/pc_fetch_ifid.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_ifid.sv
// Program counter and IF/ID pipeline register for the RV32I fetch stage.
// The PC drives a zero-latency instruction memory through a word address.
// The returned instruction is captured into IF/ID for decode.
// A redirect wins over a stall, and a stall wins over a normal advance.
// A redirect to an address that is not word-aligned locks the block in ERR
// until reset.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal fetch: advance, hold on stall, or redirect
// ERR   | misaligned redirect seen; PC frozen, IF/ID holds a NOP bubble

module pc_fetch_ifid #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] imem_addr,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] fetch_count,
   output logic        misaligned_err
);

   typedef enum logic {
      RUN = 1'b0,
      ERR = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] ipc4_q, ipc4_d;
   logic [31:0] count_q, count_d;
   logic        err_q, err_d;
   logic        target_aligned;

   assign target_aligned = (redirect_pc[1:0] == 2'b00);

   // State and datapath registers; reset discards everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         ipc_q   <= 32'h0000_0000;
         ipc4_q  <= 32'h0000_0004;
         count_q <= 32'h0000_0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         ipc4_q  <= ipc4_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: redirect over stall over advance; ERR only holds.
   // On a flush the IF/ID PC fields keep their last values, because valid=0
   // marks them as meaningless to decode.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      count_d = count_q;
      err_d   = err_q;
      unique case (state_q)
         RUN: begin
            if (redirect_valid) begin
               instr_d = NOP_INSTR;
               valid_d = 1'b0;
               if (target_aligned) begin
                  pc_d = redirect_pc;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end else if (!stall) begin
               instr_d = instr_in;
               ipc_d   = pc_q;
               ipc4_d  = pc_q + 32'd4;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               count_d = count_q + 32'd1;
            end
         end
         ERR: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            err_d   = 1'b1;
         end
         default: begin
            state_d = ERR;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            err_d   = 1'b1;
         end
      endcase
   end

   assign pc_out         = pc_q;
   assign imem_addr      = {2'b00, pc_q[31:2]};
   assign if_id_valid    = valid_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc       = ipc_q;
   assign if_id_pc_plus4 = ipc4_q;
   assign fetch_count    = count_q;
   assign misaligned_err = err_q;

endmodule
